// File: rtl/systolic_tile_sequencer.sv
// Sequences matrix tiles through a systolic array: issues a start per tile,
// streams K paired activation/weight beats, then drains DIM result rows.
module systolic_tile_sequencer #(
    parameter int SYSTOLIC_ARRAY_DIM = 8,
    parameter int DATA_WIDTH_BITS    = 16,
    parameter int TILE_CNT_BITS      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [19:0]                                   cmd_inner_dim,
    input  logic [TILE_CNT_BITS-1:0]                      cmd_num_tiles,
    input  logic                                          act_in_valid,
    output logic                                          act_in_ready,
    input  logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] act_in,
    input  logic                                          wgt_in_valid,
    output logic                                          wgt_in_ready,
    input  logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] wgt_in,
    output logic                                          sa_act_valid,
    input  logic                                          sa_act_ready,
    output logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] sa_act,
    output logic                                          sa_wgt_valid,
    input  logic                                          sa_wgt_ready,
    output logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] sa_wgt,
    output logic                                          sa_start,
    input  logic                                          sa_start_ready,
    output logic [19:0]                                   sa_inner_dim,
    input  logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] sa_out,
    input  logic                                          sa_out_valid,
    output logic                                          sa_out_ready,
    output logic [SYSTOLIC_ARRAY_DIM*DATA_WIDTH_BITS-1:0] out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_tile_last,
    output logic                                          out_job_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err_cmd,
    output logic [TILE_CNT_BITS-1:0]                      tiles_done
);

    localparam int ROW_BITS = $clog2(SYSTOLIC_ARRAY_DIM + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        FEED,
        COLLECT,
        FINISH
    } state_t;

    state_t                   state, state_d;
    logic [19:0]              k_q, k_d;
    logic [TILE_CNT_BITS-1:0] tiles_q, tiles_d;
    logic [TILE_CNT_BITS-1:0] tiles_done_d;
    logic [19:0]              feed_ctr, feed_d;
    logic [ROW_BITS-1:0]      row_ctr, row_d;
    logic                     err_q, err_d;
    logic                     beat;
    logic                     row_hs;
    logic                     last_tile;

    // Operand streams pass straight through; only the handshakes are gated.
    assign sa_act       = act_in;
    assign sa_wgt       = wgt_in;
    assign sa_inner_dim = k_q;

    assign beat      = act_in_valid && wgt_in_valid && sa_act_ready && sa_wgt_ready;
    assign row_hs    = sa_out_valid && out_ready;
    assign last_tile = (tiles_done == tiles_q - TILE_CNT_BITS'(1));

    assign out_tile_last = (state == COLLECT) && (row_ctr == ROW_BITS'(1));
    assign out_job_last  = out_tile_last && last_tile;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k_q        <= '0;
            tiles_q    <= '0;
            tiles_done <= '0;
            feed_ctr   <= '0;
            row_ctr    <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            k_q        <= k_d;
            tiles_q    <= tiles_d;
            tiles_done <= tiles_done_d;
            feed_ctr   <= feed_d;
            row_ctr    <= row_d;
            err_q      <= err_d;
        end
    end

    // Next-state, counter updates and handshake outputs per state.
    always_comb begin
        state_d      = state;
        k_d          = k_q;
        tiles_d      = tiles_q;
        tiles_done_d = tiles_done;
        feed_d       = feed_ctr;
        row_d        = row_ctr;
        err_d        = 1'b0;
        cmd_ready    = 1'b0;
        sa_start     = 1'b0;
        act_in_ready = 1'b0;
        wgt_in_ready = 1'b0;
        sa_act_valid = 1'b0;
        sa_wgt_valid = 1'b0;
        sa_out_ready = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        busy         = 1'b1;
        done         = err_q;
        err_cmd      = err_q;

        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if ((cmd_inner_dim != '0) && (cmd_num_tiles != '0)) begin
                        k_d          = cmd_inner_dim;
                        tiles_d      = cmd_num_tiles;
                        tiles_done_d = '0;
                        state_d      = START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            START: begin
                sa_start = sa_start_ready;
                if (sa_start_ready) begin
                    feed_d  = k_q;
                    state_d = FEED;
                end
            end
            FEED: begin
                sa_act_valid = act_in_valid && wgt_in_valid;
                sa_wgt_valid = act_in_valid && wgt_in_valid;
                act_in_ready = beat;
                wgt_in_ready = beat;
                if (beat) begin
                    feed_d = feed_ctr - 20'd1;
                    if (feed_ctr == 20'd1) begin
                        row_d   = ROW_BITS'(SYSTOLIC_ARRAY_DIM);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                out_data     = sa_out;
                out_valid    = sa_out_valid;
                sa_out_ready = out_ready;
                if (row_hs) begin
                    row_d = row_ctr - ROW_BITS'(1);
                    if (row_ctr == ROW_BITS'(1)) begin
                        tiles_done_d = tiles_done + TILE_CNT_BITS'(1);
                        state_d      = last_tile ? FINISH : START;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Randomized bench for systolic_tile_sequencer against a job-level model that
// tracks tiles started, beats fed and rows drained.
module tb_systolic_tile_sequencer;

    localparam int DIM = 8;
    localparam int DW  = 16;
    localparam int TB  = 16;
    localparam int W   = DIM * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [19:0]   cmd_inner_dim;
    logic [TB-1:0] cmd_num_tiles;
    logic          act_in_valid, act_in_ready;
    logic [W-1:0]  act_in;
    logic          wgt_in_valid, wgt_in_ready;
    logic [W-1:0]  wgt_in;
    logic          sa_act_valid, sa_act_ready;
    logic [W-1:0]  sa_act;
    logic          sa_wgt_valid, sa_wgt_ready;
    logic [W-1:0]  sa_wgt;
    logic          sa_start, sa_start_ready;
    logic [19:0]   sa_inner_dim;
    logic [W-1:0]  sa_out;
    logic          sa_out_valid, sa_out_ready;
    logic [W-1:0]  out_data;
    logic          out_valid, out_ready, out_tile_last, out_job_last;
    logic          busy, done, err_cmd;
    logic [TB-1:0] tiles_done;

    systolic_tile_sequencer #(
        .SYSTOLIC_ARRAY_DIM(DIM),
        .DATA_WIDTH_BITS   (DW),
        .TILE_CNT_BITS     (TB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_inner_dim(cmd_inner_dim), .cmd_num_tiles(cmd_num_tiles),
        .act_in_valid(act_in_valid), .act_in_ready(act_in_ready), .act_in(act_in),
        .wgt_in_valid(wgt_in_valid), .wgt_in_ready(wgt_in_ready), .wgt_in(wgt_in),
        .sa_act_valid(sa_act_valid), .sa_act_ready(sa_act_ready), .sa_act(sa_act),
        .sa_wgt_valid(sa_wgt_valid), .sa_wgt_ready(sa_wgt_ready), .sa_wgt(sa_wgt),
        .sa_start(sa_start), .sa_start_ready(sa_start_ready), .sa_inner_dim(sa_inner_dim),
        .sa_out(sa_out), .sa_out_valid(sa_out_valid), .sa_out_ready(sa_out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_tile_last(out_tile_last), .out_job_last(out_job_last),
        .busy(busy), .done(done), .err_cmd(err_cmd), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Job-level reference state.
    bit active, err_exp, last_beat, last_row;
    int k_m, t_m, starts, beats, rows, exp_td;
    int mode, cyc;
    int obs_starts, obs_beats, obs_rows, obs_tl, obs_jl, obs_done, obs_err;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int unsigned i = 0; i < W; i += 32) v[i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic pick();
        return (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic model_reset();
        active = 0; err_exp = 0; last_beat = 0; last_row = 0;
        k_m = 0; t_m = 0; starts = 0; beats = 0; rows = 0; exp_td = 0;
    endtask

    task automatic clear_obs();
        obs_starts = 0; obs_beats = 0; obs_rows = 0; obs_tl = 0;
        obs_jl = 0; obs_done = 0; obs_err = 0;
    endtask

    // Drive one cycle of inputs; unconsumed valid data is held stable.
    task automatic drive(input bit c_v, input logic [19:0] c_k, input logic [TB-1:0] c_t);
        cyc++;
        cmd_valid     = c_v;
        cmd_inner_dim = c_v ? c_k : 20'($urandom());
        cmd_num_tiles = c_v ? c_t : TB'($urandom());
        if (!(act_in_valid && !last_beat)) begin
            act_in_valid = pick();
            act_in       = rnd_vec();
        end
        if (!(wgt_in_valid && !last_beat)) begin
            wgt_in_valid = pick();
            wgt_in       = rnd_vec();
        end
        if (!(sa_out_valid && !last_row)) begin
            sa_out_valid = pick();
            sa_out       = rnd_vec();
        end
        sa_act_ready   = pick();
        sa_wgt_ready   = pick();
        sa_start_ready = pick();
        out_ready      = pick();
        if (mode == 2) wgt_in_valid = !(cyc >= 3 && cyc < 8);
        if (mode == 3) out_ready = cyc[0];
    endtask

    // Compare every output with what the job-level model predicts this cycle.
    task automatic eval();
        bit ph_fin, ph_start, ph_feed, ph_coll, e_beat, e_row, e_start, e_tl, err_next;
        ph_fin   = active && (rows == t_m * DIM);
        ph_start = active && !ph_fin && (rows == starts * DIM);
        ph_feed  = active && !ph_fin && !ph_start && (beats < starts * k_m);
        ph_coll  = active && !ph_fin && !ph_start && !ph_feed;
        if (active) exp_td = rows / DIM;
        e_beat  = ph_feed && act_in_valid && wgt_in_valid && sa_act_ready && sa_wgt_ready;
        e_row   = ph_coll && sa_out_valid && out_ready;
        e_start = ph_start && sa_start_ready;
        e_tl    = ph_coll && ((rows % DIM) == DIM - 1);

        check("busy",          W'(busy),          W'(active));
        check("cmd_ready",     W'(cmd_ready),     W'(!active));
        check("sa_start",      W'(sa_start),      W'(e_start));
        check("act_in_ready",  W'(act_in_ready),  W'(e_beat));
        check("wgt_in_ready",  W'(wgt_in_ready),  W'(e_beat));
        check("sa_act_valid",  W'(sa_act_valid),  W'(ph_feed && act_in_valid && wgt_in_valid));
        check("sa_wgt_valid",  W'(sa_wgt_valid),  W'(ph_feed && act_in_valid && wgt_in_valid));
        check("sa_act",        sa_act,            act_in);
        check("sa_wgt",        sa_wgt,            wgt_in);
        check("sa_out_ready",  W'(sa_out_ready),  W'(ph_coll && out_ready));
        check("out_valid",     W'(out_valid),     W'(ph_coll && sa_out_valid));
        check("out_tile_last", W'(out_tile_last), W'(e_tl));
        check("out_job_last",  W'(out_job_last),  W'(e_tl && (rows == t_m * DIM - 1)));
        check("done",          W'(done),          W'(ph_fin || err_exp));
        check("err_cmd",       W'(err_cmd),       W'(err_exp));
        check("tiles_done",    W'(tiles_done),    W'(exp_td));
        if (active) check("sa_inner_dim", W'(sa_inner_dim), W'(k_m));
        if (ph_coll) check("out_data", out_data, sa_out);

        obs_starts += int'(sa_start && sa_start_ready);
        obs_beats  += int'(act_in_ready && act_in_valid);
        obs_rows   += int'(sa_out_ready && sa_out_valid);
        obs_tl     += int'(out_tile_last && sa_out_ready && sa_out_valid);
        obs_jl     += int'(out_job_last && sa_out_ready && sa_out_valid);
        obs_done   += int'(done);
        obs_err    += int'(err_cmd);

        starts += int'(e_start);
        beats  += int'(e_beat);
        rows   += int'(e_row);
        last_beat = e_beat;
        last_row  = e_row;
        err_next  = 0;
        if (cmd_valid && !active) begin
            if (cmd_inner_dim == 0 || cmd_num_tiles == 0) begin
                err_next = 1;
            end else begin
                active = 1;
                k_m    = int'(cmd_inner_dim);
                t_m    = int'(cmd_num_tiles);
                starts = 0; beats = 0; rows = 0;
            end
        end else if (ph_fin) begin
            active = 0;
        end
        err_exp = err_next;
    endtask

    task automatic step(input bit c_v, input logic [19:0] c_k, input logic [TB-1:0] c_t);
        @(posedge clk); #1;
        drive(c_v, c_k, c_t);
        @(negedge clk);
        eval();
    endtask

    task automatic finish_job(input int k, input int t);
        int budget = 4000;
        while (active && budget > 0) begin
            step(0, '0, '0);
            budget--;
        end
        check("job_timeout", W'(active), '0);
        step(0, '0, '0);
        check("job_starts",    W'(obs_starts), W'(t));
        check("job_beats",     W'(obs_beats),  W'(k * t));
        check("job_rows",      W'(obs_rows),   W'(DIM * t));
        check("job_tile_last", W'(obs_tl),     W'(t));
        check("job_job_last",  W'(obs_jl),     W'(1));
        check("job_done",      W'(obs_done),   W'(1));
        check("job_err",       W'(obs_err),    W'(0));
        check("job_tiles_done", W'(tiles_done), W'(t));
    endtask

    task automatic run_job(input int k, input int t, input int md);
        mode = md; cyc = 0;
        clear_obs();
        step(1, 20'(k), TB'(t));
        finish_job(k, t);
    endtask

    task automatic bad_cmd(input int k, input int t);
        logic [TB-1:0] td_before;
        mode = 1; cyc = 0;
        clear_obs();
        td_before = tiles_done;
        step(1, 20'(k), TB'(t));
        step(0, '0, '0);
        step(0, '0, '0);
        check("bad_done",   W'(obs_done),   W'(1));
        check("bad_err",    W'(obs_err),    W'(1));
        check("bad_starts", W'(obs_starts), W'(0));
        check("bad_td",     W'(tiles_done), W'(td_before));
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_inner_dim = '0; cmd_num_tiles = '0;
        act_in_valid = 0; act_in = '0; wgt_in_valid = 0; wgt_in = '0;
        sa_act_ready = 0; sa_wgt_ready = 0; sa_start_ready = 0;
        sa_out_valid = 0; sa_out = '0; out_ready = 0;
        mode = 0; cyc = 0;
        model_reset();
        clear_obs();

        #2;
        check("rst_busy",       W'(busy),         '0);
        check("rst_cmd_ready",  W'(cmd_ready),    W'(1));
        check("rst_done",       W'(done),         '0);
        check("rst_err",        W'(err_cmd),      '0);
        check("rst_tiles_done", W'(tiles_done),   '0);
        check("rst_sa_start",   W'(sa_start),     '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(4, 1, 1);
        run_job(3, 3, 1);
        run_job(6, 1, 2);
        run_job(2, 2, 3);
        run_job(1, 1, 0);
        repeat (6) run_job($urandom_range(1, 6), $urandom_range(1, 4), 0);

        bad_cmd(0, 2);
        bad_cmd(5, 0);

        // Abandon a job partway through feeding, then restart immediately.
        mode = 1; cyc = 0;
        clear_obs();
        step(1, 20'd4, TB'(1));
        budget = 100;
        while (beats < 2 && budget > 0) begin
            step(0, '0, '0);
            budget--;
        end
        check("midfeed_reach", W'(beats), W'(2));
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_cmd_ready",  W'(cmd_ready),    W'(1));
        check("midrst_busy",       W'(busy),         '0);
        check("midrst_done",       W'(done),         '0);
        check("midrst_tiles_done", W'(tiles_done),   '0);
        check("midrst_act_ready",  W'(act_in_ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        drive(1, 20'd2, TB'(1));
        #1;
        eval();
        finish_job(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
